// File: rtl/arbitro_escritura_reg_if.sv
// Bundle of the write-back arbiter's ALU/load/issue/query inputs and its
// register-file write port; master drives the pipeline side, slave is the arbiter.
interface arbitro_escritura_reg_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  query_addr1;
  logic [4:0]  query_addr2;
  logic        busy1;
  logic        busy2;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd, query_addr1, query_addr2,
    input  alu_ready, mem_ready, busy1, busy2, write_enable, write_addr, write_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd, query_addr1, query_addr2,
    output alu_ready, mem_ready, busy1, busy2, write_enable, write_addr, write_data
  );
endinterface

// File: rtl/arbitro_escritura_reg.sv
// Register-file write-port arbiter: ALU results vs. a FIFO of load results, with
// an optional pending-write busy vector compiled in by macro SCOREBOARD_EN.
module arbitro_escritura_reg #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  arbitro_escritura_reg_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [36:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        fifo_full, fifo_empty;
  logic        push, pop, drain_alu, drain_en;
  logic [4:0]  drain_rd;
  logic [31:0] drain_data;

  logic        write_enable_q, write_enable_d;
  logic [4:0]  write_addr_q, write_addr_d;
  logic [31:0] write_data_q, write_data_d;

  // Drain selection: a full FIFO forces its head out and stalls the ALU;
  // otherwise the ALU wins and the FIFO only drains in ALU-idle cycles.
  always_comb begin
    fifo_full  = (count_q == DEPTH_C);
    fifo_empty = (count_q == '0);
    push       = bus.mem_valid && !fifo_full;
    drain_alu  = !fifo_full && bus.alu_valid;
    pop        = fifo_full || (!bus.alu_valid && !fifo_empty);
    drain_en   = drain_alu || pop;
    drain_rd   = drain_alu ? bus.alu_rd   : fifo_mem[rd_ptr_q][36:32];
    drain_data = drain_alu ? bus.alu_data : fifo_mem[rd_ptr_q][31:0];

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    // x0 writes are consumed but never reach the register file
    write_enable_d = drain_en && (drain_rd != 5'd0);
    write_addr_d   = write_enable_d ? drain_rd   : write_addr_q;
    write_data_d   = write_enable_d ? drain_data : write_data_q;
  end

  // Storage stage: payload only, validity lives in the pointers/count
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {bus.mem_rd, bus.mem_data};
  end

  // Write-port stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      write_enable_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      write_enable_q <= write_enable_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
    end
  end

  assign bus.mem_ready    = !fifo_full;
  assign bus.alu_ready    = !fifo_full;
  assign bus.write_enable = write_enable_q;
  assign bus.write_addr   = write_addr_q;
  assign bus.write_data   = write_data_q;

`ifdef SCOREBOARD_EN
  logic [31:0] busy_q, busy_d, busy_set, busy_clr;

  // A new issue to a register outranks the retiring write of its older value
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) busy_set[bus.issue_rd] = 1'b1;
    if (write_enable_q) busy_clr[write_addr_q] = 1'b1;
    busy_d = (busy_q & ~busy_clr) | busy_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign bus.busy1 = (bus.query_addr1 != 5'd0) && busy_q[bus.query_addr1];
  assign bus.busy2 = (bus.query_addr2 != 5'd0) && busy_q[bus.query_addr2];
`else
  logic unused_scoreboard_inputs;
  assign unused_scoreboard_inputs = ^{bus.issue_valid, bus.issue_rd,
                                      bus.query_addr1, bus.query_addr2};
  assign bus.busy1 = 1'b0;
  assign bus.busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_escritura_reg.sv
// Directed + randomised bench for arbitro_escritura_reg using a reference FIFO
// model and a queue of expected register-file writes.
module tb_arbitro_escritura_reg;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arbitro_escritura_reg_if bus();

  arbitro_escritura_reg #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  logic [36:0] mq[$];
  exp_t        expq[$];
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_we = 1'b0;
  logic [4:0]  cur_addr = '0;
  logic [31:0] busy_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic busy_exp(input logic [4:0] q);
`ifdef SCOREBOARD_EN
    return (q != 5'd0) && busy_m[q];
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_rd      = '0;
    bus.mem_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.query_addr1 = '0;
    bus.query_addr2 = '0;
  endtask

  task automatic model_reset();
    mq.delete();
    expq.delete();
    m_addr   = '0;
    m_data   = '0;
    m_we     = 1'b0;
    cur_addr = '0;
    busy_m   = '0;
  endtask

  // One clock with the currently driven inputs; predicts, then compares after the edge.
  task automatic cycle();
    logic        full;
    logic        drn;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [36:0] e;
    logic [31:0] set_v;
    logic [31:0] clr_v;
    exp_t        x;
    full = (mq.size() == DEPTH);
    check("mem_ready", 32'(bus.mem_ready), 32'(!full));
    check("alu_ready", 32'(bus.alu_ready), 32'(!full));
    set_v = '0;
    clr_v = '0;
    if (bus.issue_valid && bus.issue_rd != 5'd0) set_v[bus.issue_rd] = 1'b1;
    if (m_we) clr_v[cur_addr] = 1'b1;
    drn = 1'b0;
    rd  = '0;
    d   = '0;
    if (!full && bus.alu_valid) begin
      drn = 1'b1;
      rd  = bus.alu_rd;
      d   = bus.alu_data;
    end else if (mq.size() != 0) begin
      e   = mq.pop_front();
      drn = 1'b1;
      rd  = e[36:32];
      d   = e[31:0];
    end
    if (bus.mem_valid && !full) mq.push_back({bus.mem_rd, bus.mem_data});
    if (drn && rd != 5'd0) begin
      m_addr = rd;
      m_data = d;
      x.we   = 1'b1;
    end else begin
      x.we   = 1'b0;
    end
    x.a = m_addr;
    x.d = m_data;
    expq.push_back(x);

    @(posedge clk);
    #1;
    x = expq.pop_front();
    check("write_enable", 32'(bus.write_enable), 32'(x.we));
    check("write_addr", 32'(bus.write_addr), 32'(x.a));
    check("write_data", bus.write_data, x.d);
    m_we     = x.we;
    cur_addr = x.a;
    busy_m   = (busy_m & ~clr_v) | set_v;
    check("busy1", 32'(bus.busy1), 32'(busy_exp(bus.query_addr1)));
    check("busy2", 32'(bus.busy2), 32'(busy_exp(bus.query_addr2)));
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_write_enable", 32'(bus.write_enable), 32'd0);
    check("rst_write_addr", 32'(bus.write_addr), 32'd0);
    check("rst_write_data", bus.write_data, 32'd0);
    check("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    rst = 1'b0;

    // Single ALU write
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEADBEEF;
    cycle();
    check("alu_wr_en", 32'(bus.write_enable), 32'd1);
    check("alu_wr_addr", 32'(bus.write_addr), 32'd5);
    check("alu_wr_data", bus.write_data, 32'hDEADBEEF);

    // Write to x0: discarded, address/data held
    bus.alu_rd   = 5'd0;
    bus.alu_data = 32'h1234;
    cycle();
    check("x0_wr_en", 32'(bus.write_enable), 32'd0);
    check("x0_hold_data", bus.write_data, 32'hDEADBEEF);
    bus.alu_valid = 1'b0;
    cycle();

    // Fill the load FIFO while the ALU keeps winning
    for (int i = 1; i <= 4; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'(10 + i);
      bus.alu_data  = 32'(i) * 32'h100;
      bus.mem_valid = 1'b1;
      bus.mem_rd    = 5'(i);
      bus.mem_data  = 32'(i) * 32'h11;
      cycle();
    end
    bus.mem_valid = 1'b0;
    bus.alu_rd    = 5'd20;
    bus.alu_data  = 32'hA0A0A0A0;
    check("full_mem_ready", 32'(bus.mem_ready), 32'd0);
    check("full_alu_ready", 32'(bus.alu_ready), 32'd0);
    cycle();
    check("full_drain_addr", 32'(bus.write_addr), 32'd1);
    check("full_drain_data", bus.write_data, 32'h11);
    cycle();
    bus.alu_valid = 1'b0;
    repeat (3) cycle();
    check("fifo_last_addr", 32'(bus.write_addr), 32'd4);
    check("fifo_last_data", bus.write_data, 32'h44);
    bus.alu_valid = 1'b1;
    cycle();
    check("alu_resume_addr", 32'(bus.write_addr), 32'd20);

    // Busy scoreboard, including same-cycle set/clear of r7
    idle();
    bus.query_addr1 = 5'd7;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    cycle();
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b1;
    bus.alu_rd      = 5'd7;
    bus.alu_data    = 32'h77;
    cycle();
    bus.alu_valid   = 1'b0;
    bus.issue_valid = 1'b1;
    cycle();
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b1;
    cycle();
    bus.alu_valid   = 1'b0;
    cycle();
    cycle();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd9;
    bus.query_addr1 = 5'd9;
    bus.query_addr2 = 5'd0;
    cycle();
    bus.issue_valid = 1'b0;
    cycle();

    // Randomised mix exercises pointer wrap and simultaneous push/pop
    for (int i = 0; i < 40; i++) begin
      bus.alu_valid   = ($urandom_range(0, 3) == 0);
      bus.alu_rd      = 5'($urandom_range(0, 31));
      bus.alu_data    = $urandom;
      bus.mem_valid   = 1'($urandom_range(0, 1));
      bus.mem_rd      = 5'($urandom_range(0, 31));
      bus.mem_data    = $urandom;
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 5'($urandom_range(0, 31));
      bus.query_addr1 = 5'($urandom_range(0, 31));
      bus.query_addr2 = 5'($urandom_range(0, 31));
      cycle();
    end

    // Reset with three loads buffered
    idle();
    for (int i = 1; i <= 3; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'(24 + i);
      bus.alu_data  = 32'(i);
      bus.mem_valid = 1'b1;
      bus.mem_rd    = 5'(i);
      bus.mem_data  = 32'hF0 + 32'(i);
      cycle();
    end
    check("pre_rst_fifo_count", 32'(mq.size()), 32'd3);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_write_enable", 32'(bus.write_enable), 32'd0);
    check("async_rst_write_addr", 32'(bus.write_addr), 32'd0);
    check("async_rst_write_data", bus.write_data, 32'd0);
    check("async_rst_mem_ready", 32'(bus.mem_ready), 32'd1);
    check("async_rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
